mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter BLOCK_BITS, default 128, meaning the width of one cache block.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the number of blocks stored.
REQ-003 The block SHALL have parameter LATENCY, default 4, meaning the clk cycles from request accept to response pulse; legal range 1..15.
REQ-004 Port list SHALL be:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present; held by the initiator until rsp_ready is seen.
- req_type  in  1  0 = block read, 1 = block write.
- req_addr  in  32  byte address; bits [3:0] ignored; block index = req_addr[31:4].
- req_data  in  BLOCK_BITS  write block.
- rsp_ready  out  1  one-cycle completion pulse.
- rsp_data  out  BLOCK_BITS  read block; valid while rsp_ready=1.
- rsp_err  out  1  index out of range; valid while rsp_ready=1.
- busy  out  1  request accepted and not yet released.

Function
REQ-005 FSM states SHALL be IDLE, WAIT, RESP and HOLD.
REQ-006 IDLE: if req_valid=1, latch req_type, block index and req_data; load the counter with LATENCY-1; go to WAIT.
REQ-007 WAIT: when the counter is 0, perform the access and go to RESP; otherwise decrement the counter; req_* inputs are ignored.
REQ-008 Access, read: rsp_data <= RAM[index] from the latched index.
REQ-009 Access, write: RAM[index] <= latched data; rsp_data <= latched data (echo).
REQ-010 Access, index >= DEPTH: rsp_err <= 1, rsp_data <= 0, RAM unchanged.
REQ-011 Access, index in range: rsp_err <= 0.
REQ-012 RESP SHALL assert rsp_ready for exactly one cycle, then go to HOLD.
REQ-013 Latency: with accept at edge N, rsp_ready SHALL be 1 in the cycle after edge N+LATENCY.
REQ-014 HOLD: stay while req_valid=1; go to IDLE on the first cycle req_valid=0; a held request SHALL never execute twice.
REQ-015 rsp_data and rsp_err SHALL keep their last values until the next access.
REQ-016 busy SHALL be 1 in WAIT, RESP and HOLD, and 0 in IDLE.
REQ-017 Changing req_* while busy=1 SHALL have no effect on the accepted operation.
REQ-018 Minimum spacing between two requests SHALL be LATENCY+3 cycles (valid-low gap of 1 cycle included).
REQ-019 With LATENCY=1, WAIT SHALL last one cycle; the counter is never negative.
REQ-020 RAM SHALL power up to zero (simulation initial block) and SHALL be writable hierarchically by benches through array RAM[0:DEPTH-1].

Reset
REQ-021 rst=0 SHALL immediately force state IDLE, counter 0, rsp_ready 0, rsp_data 0, rsp_err 0 and busy 0.
REQ-022 RAM contents SHALL NOT be cleared by reset.
REQ-023 Reset during WAIT SHALL abort the operation; a pending write SHALL NOT be committed.
REQ-024 After rst returns to 1, a still-asserted req_valid SHALL be accepted as a new request on the next edge.

Verification
REQ-025 Write then read, LATENCY=4:
- Stimulus: write addr 0x10 data 0xaabbccdd_00000000_11111111_22222222; drop valid; read addr 0x1c.
- Response: both ops pulse rsp_ready 5 cycles after accept; the read returns the same data; rsp_err=0.
REQ-026 Held valid: keep req_valid=1 for 20 cycles after the read pulse -> exactly one rsp_ready pulse; busy stays 1 until valid drops.
REQ-027 Out of range: read addr 0x1000 (index 256) with DEPTH=256 -> rsp_err=1, rsp_data=0; RAM unchanged.
REQ-028 Reset mid-write:
- Stimulus: write 0x5 to index 3; pull rst low at accept+2.
- Response: all outputs 0 at once; after release, a read of index 3 returns its prior value.
REQ-029 Input change while busy: change req_addr and req_data during WAIT -> the result reflects the originally latched values.
REQ-030 LATENCY=1 and LATENCY=15 builds: rsp_ready pulse arrives exactly 2 and 16 cycles after accept respectively.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding block memory responder with a fixed,
// parameterised access latency. One request is accepted from IDLE, the
// access happens after LATENCY cycles, a one-cycle rsp_ready pulse follows,
// and the FSM parks in HOLD until the initiator drops req_valid so a held
// request can never be executed a second time.
module mem_responder #(
    parameter int unsigned BLOCK_BITS = 128,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_type,
    input  logic [31:0]           req_addr,
    input  logic [BLOCK_BITS-1:0] req_data,
    output logic                  rsp_ready,
    output logic [BLOCK_BITS-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int unsigned AddrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DepthW   = 32'(DEPTH);
    // LATENCY is limited to 1..15, so the countdown fits in four bits.
    localparam logic [3:0]  CntLoad  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp,
        StHold
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [27:0]             idx_q, idx_d;
    logic [BLOCK_BITS-1:0]   wdata_q, wdata_d;
    logic [BLOCK_BITS-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    in_range;
    logic                    mem_we;
    logic [BLOCK_BITS-1:0]   ram_rd;

    // Block storage; no reset so contents survive rst.
    logic [BLOCK_BITS-1:0]   RAM [0:DEPTH-1];

    // Byte offset within a block carries no meaning here.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[3:0];

    assign in_range = ({4'b0000, idx_q} < DepthW);
    assign ram_rd   = RAM[idx_q[AddrW-1:0]];
    assign busy     = (state_q != StIdle);
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

    // Next-state, request latching, access decode and the response pulse.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        mem_we     = 1'b0;
        rsp_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_type;
                    idx_d   = req_addr[31:4];
                    wdata_d = req_data;
                    cnt_d   = CntLoad;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    if (!in_range) begin
                        // Out-of-range index: flag it, return zero, leave RAM alone.
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end else begin
                        rsp_err_d = 1'b0;
                        if (we_q) begin
                            mem_we     = 1'b1;
                            rsp_data_d = wdata_q;
                        end else begin
                            rsp_data_d = ram_rd;
                        end
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                rsp_ready = 1'b1;
                state_d   = StHold;
            end
            StHold: begin
                // Wait for the initiator to release the request it already got served.
                if (!req_valid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and response registers; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // RAM write port; mem_we is only raised from WAIT, which reset forces out of.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            RAM[idx_q[AddrW-1:0]] <= wdata_q;
        end
    end

endmodule
